// File: rtl/uart_receiver.sv
// UART receive stage: 16x-oversampled 8N1 deserialiser with mid-bit sampling.
// Emits one rx_valid strobe per good frame and one rx_frame_err strobe per bad stop bit.
module uart_receiver #(
  parameter int unsigned BAUD_RATE  = 1156000,
  parameter int unsigned CLOCK_FREQ = 75000000,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_frame_err,
  output logic                  rx_busy
);

  localparam int unsigned OS_DIV_RAW = (CLOCK_FREQ + BAUD_RATE * OVERSAMPLE / 2) /
                                       (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned OS_DIV     = (OS_DIV_RAW == 0) ? 1 : OS_DIV_RAW;
  localparam int unsigned DIV_W      = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int unsigned CNT_W      = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W      = $clog2(DATA_WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OS_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state;
  logic                  sync_1;
  logic                  rx_s;
  logic                  rx_s_d;
  logic [DIV_W-1:0]      div_cnt;
  logic [CNT_W-1:0]      os_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  os_tick;

  // Synchroniser and edge-detect delay reset to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      sync_1 <= rx_in;
      rx_s   <= sync_1;
      rx_s_d <= rx_s;
    end
  end

  assign os_tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      os_cnt       <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;

      if (state != IDLE) begin
        div_cnt <= os_tick ? '0 : div_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          // Requires a real 1->0 transition, so a held-low line cannot retrigger.
          if (rx_s_d && !rx_s) begin
            state   <= START;
            div_cnt <= '0;
            os_cnt  <= '0;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (os_tick) begin
            if (os_cnt == CNT_HALF) begin
              os_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (os_tick) begin
            if (os_cnt == CNT_LAST) begin
              os_cnt <= '0;
              shift  <= DATA_WIDTH'({rx_s, shift} >> 1);
              if (bit_cnt == BIT_LAST) begin
                state   <= STOP;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          // Returning to IDLE at mid stop bit leaves half a bit to catch the next start edge.
          if (os_tick) begin
            if (os_cnt == CNT_LAST) begin
              os_cnt  <= '0;
              state   <= IDLE;
              rx_busy <= 1'b0;
              if (rx_s) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                rx_frame_err <= 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
